// File: rtl/sw_array_ctrl_pkg.sv
// Shared types for the Smith-Waterman array sequencer: score width, head
// token encodings, FSM states and the latched scoring configuration.
package sw_array_ctrl_pkg;
  localparam int CALC_BIT = 16;

  localparam logic [2:0] TOK_BUBBLE = 3'b000;
  localparam logic [2:0] TOK_MARK   = 3'b001;
  localparam logic [2:0] TOK_VALID  = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOADQ, ST_MARK, ST_STREAM, ST_DRAIN, ST_DONE
  } state_e;

  typedef struct packed {
    logic signed [CALC_BIT-1:0] match;
    logic signed [CALC_BIT-1:0] mismatch;
    logic signed [CALC_BIT-1:0] alpha;
    logic signed [CALC_BIT-1:0] beta;
  } sw_cfg_t;

  function automatic logic signed [CALC_BIT-1:0] smax(
    input logic signed [CALC_BIT-1:0] a,
    input logic signed [CALC_BIT-1:0] b
  );
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/sw_q_bank.sv
// Query register file: one {active, nt} entry per PE, bulk clear plus one
// indexed write per cycle, presented flat to the chain.
module sw_q_bank
  import sw_array_ctrl_pkg::*;
#(
  parameter int PE_NUM  = 64,
  parameter int CNT_BIT = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clr,
  input  logic                  i_we,
  input  logic [CNT_BIT-1:0]    i_addr,
  input  logic [1:0]            i_nt,
  output logic [3*PE_NUM-1:0]   o_q
);
  for (genvar g = 0; g < PE_NUM; g++) begin : g_pe
    logic       w_hit;
    logic [2:0] r_ent;

    assign w_hit = i_we && (i_addr == CNT_BIT'(g));

    // A write to this entry takes priority over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     r_ent <= '0;
      else if (w_hit) r_ent <= TOK_VALID | {1'b0, i_nt};
      else if (i_clr) r_ent <= '0;
    end

    assign o_q[3*g +: 3] = r_ent;
  end
endmodule

// File: rtl/sw_array_ctrl.sv
// Sequencer for the Smith-Waterman PE chain: query load, target injection,
// drain and best-score reduction of the chain tail.
module sw_array_ctrl
  import sw_array_ctrl_pkg::*;
#(
  parameter int PE_NUM  = 64,
  parameter int CNT_BIT = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [CALC_BIT-1:0] cfg_match,
  input  logic signed [CALC_BIT-1:0] cfg_mismatch,
  input  logic signed [CALC_BIT-1:0] cfg_alpha,
  input  logic signed [CALC_BIT-1:0] cfg_beta,
  input  logic                       q_valid,
  input  logic [1:0]                 q_data,
  input  logic                       q_last,
  output logic                       q_ready,
  input  logic                       start,
  input  logic                       t_valid,
  input  logic [1:0]                 t_data,
  input  logic                       t_last,
  output logic                       t_ready,
  output logic [2:0]                 arr_t,
  output logic [3*PE_NUM-1:0]        arr_q,
  output logic signed [CALC_BIT-1:0] arr_match,
  output logic signed [CALC_BIT-1:0] arr_mismatch,
  output logic signed [CALC_BIT-1:0] arr_alpha,
  output logic signed [CALC_BIT-1:0] arr_beta,
  output logic signed [CALC_BIT-1:0] arr_v,
  output logic signed [CALC_BIT-1:0] arr_v_a,
  output logic signed [CALC_BIT-1:0] arr_f_b,
  output logic signed [CALC_BIT-1:0] arr_max,
  input  logic signed [CALC_BIT-1:0] arr_v_tail,
  input  logic signed [CALC_BIT-1:0] arr_max_tail,
  output logic                       res_valid,
  output logic signed [CALC_BIT-1:0] res_score,
  output logic                       res_err,
  input  logic                       res_ready,
  output logic                       busy
);
  localparam logic [CNT_BIT-1:0] LAST_POS   = CNT_BIT'(PE_NUM - 1);
  localparam logic [CNT_BIT-1:0] DRAIN_INIT = CNT_BIT'(PE_NUM + 2);

  state_e                     r_state, w_nxt;
  logic [CNT_BIT-1:0]         r_q_cnt, r_q_len, r_drain, w_bank_addr;
  logic                       w_bank_clr, w_bank_we, w_start_acc, w_q_done;
  sw_cfg_t                    r_cfg;
  logic signed [CALC_BIT-1:0] r_acc;
  logic [2:0]                 r_arr_t;
  logic                       r_err;
  logic                       w_run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt       = r_state;
    q_ready     = 1'b0;
    t_ready     = 1'b0;
    w_bank_clr  = 1'b0;
    w_bank_we   = 1'b0;
    w_bank_addr = r_q_cnt;
    w_start_acc = 1'b0;
    w_q_done    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        // start owns the cycle, so a coincident query beat is held off
        q_ready = !start;
        if (start) begin
          if (r_q_len != '0) begin
            w_start_acc = 1'b1;
            w_nxt       = ST_MARK;
          end
        end else if (q_valid) begin
          w_bank_clr  = 1'b1;
          w_bank_we   = 1'b1;
          w_bank_addr = '0;
          if (q_last || LAST_POS == '0) w_q_done = 1'b1;
          else                          w_nxt    = ST_LOADQ;
        end
      end
      ST_LOADQ: begin
        q_ready = (r_q_cnt <= LAST_POS);
        if (q_valid && r_q_cnt <= LAST_POS) begin
          w_bank_we = 1'b1;
          if (q_last || r_q_cnt == LAST_POS) begin
            w_q_done = 1'b1;
            w_nxt    = ST_IDLE;
          end
        end
      end
      ST_MARK:   w_nxt = ST_STREAM;
      ST_STREAM: begin
        t_ready = 1'b1;
        if (t_valid && t_last) w_nxt = ST_DRAIN;
      end
      ST_DRAIN: if (r_drain == '0) w_nxt = ST_DONE;
      ST_DONE:  if (res_ready) w_nxt = ST_IDLE;
      default:  w_nxt = ST_IDLE;
    endcase
  end

  assign w_run = (r_state == ST_MARK) || (r_state == ST_STREAM) || (r_state == ST_DRAIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q_cnt <= '0;
      r_q_len <= '0;
      r_drain <= '0;
      r_cfg   <= '0;
      r_acc   <= '0;
      r_arr_t <= TOK_BUBBLE;
      r_err   <= 1'b0;
    end else begin
      if (w_bank_we) r_q_cnt <= w_bank_addr + 1'b1;
      if (w_q_done)        r_q_len <= w_bank_addr + 1'b1;
      else if (w_bank_clr) r_q_len <= '0;

      // acc starts at 0 so the running max never goes negative
      if (w_start_acc) begin
        r_cfg <= '{match: cfg_match, mismatch: cfg_mismatch,
                   alpha: cfg_alpha, beta: cfg_beta};
        r_acc <= '0;
        r_err <= 1'b0;
      end else if (w_run) begin
        r_acc <= smax(r_acc, smax(arr_max_tail, arr_v_tail));
      end

      // The PEs have no stall, so an underrun is injected as a bubble and flagged.
      if (r_state == ST_STREAM && !t_valid) r_err <= 1'b1;

      case (r_state)
        ST_MARK:   r_arr_t <= TOK_MARK;
        ST_STREAM: r_arr_t <= t_valid ? (TOK_VALID | {1'b0, t_data}) : TOK_BUBBLE;
        default:   r_arr_t <= TOK_BUBBLE;
      endcase

      if (r_state == ST_STREAM && t_valid && t_last) r_drain <= DRAIN_INIT;
      else if (r_state == ST_DRAIN && r_drain != '0) r_drain <= r_drain - 1'b1;
    end
  end

  sw_q_bank #(.PE_NUM(PE_NUM), .CNT_BIT(CNT_BIT)) u_q_bank (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_bank_clr),
    .i_we   (w_bank_we),
    .i_addr (w_bank_addr),
    .i_nt   (q_data),
    .o_q    (arr_q)
  );

  assign arr_t        = r_arr_t;
  assign arr_match    = r_cfg.match;
  assign arr_mismatch = r_cfg.mismatch;
  assign arr_alpha    = r_cfg.alpha;
  assign arr_beta     = r_cfg.beta;
  assign arr_v        = '0;
  assign arr_max      = '0;
  assign arr_v_a      = r_cfg.alpha;
  assign arr_f_b      = r_cfg.alpha;
  assign res_valid    = (r_state == ST_DONE);
  assign res_score    = r_acc;
  assign res_err      = r_err;
  assign busy         = (r_state != ST_IDLE) && (r_state != ST_LOADQ);
endmodule

// File: tb/tb_sw_array_ctrl.sv
// Directed bench for sw_array_ctrl with a stub chain tail, a token scoreboard
// and an affine-gap Smith-Waterman reference for the expected scores.
module tb_sw_array_ctrl;
  import sw_array_ctrl_pkg::*;
  localparam int PE = 8;
  localparam int CB = CALC_BIT;

  logic clk = 1'b0, rst_n = 1'b1;
  logic signed [CB-1:0] cfg_match, cfg_mismatch, cfg_alpha, cfg_beta;
  logic q_valid, q_last, q_ready, start, t_valid, t_last, t_ready;
  logic [1:0] q_data, t_data;
  logic [2:0] arr_t;
  logic [3*PE-1:0] arr_q;
  logic signed [CB-1:0] arr_match, arr_mismatch, arr_alpha, arr_beta;
  logic signed [CB-1:0] arr_v, arr_v_a, arr_f_b, arr_max, arr_v_tail, arr_max_tail, res_score;
  logic res_valid, res_err, res_ready, busy;

  int checks = 0, errors = 0, cyc = 0;
  int ma = 2, mm = -1, al = -2, be = -1;
  int qlen = 0, peak_i = 0, win_len = 0, win_pos = 0;
  logic [1:0] qq[0:7];
  logic [1:0] tq[0:15];
  logic signed [CB-1:0] sb_score[$];
  bit sb_err[$];
  logic [2:0] exp_tok[$];

  sw_array_ctrl #(.PE_NUM(PE), .CNT_BIT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_match(cfg_match), .cfg_mismatch(cfg_mismatch), .cfg_alpha(cfg_alpha), .cfg_beta(cfg_beta),
    .q_valid(q_valid), .q_data(q_data), .q_last(q_last), .q_ready(q_ready),
    .start(start), .t_valid(t_valid), .t_data(t_data), .t_last(t_last), .t_ready(t_ready),
    .arr_t(arr_t), .arr_q(arr_q),
    .arr_match(arr_match), .arr_mismatch(arr_mismatch), .arr_alpha(arr_alpha), .arr_beta(arr_beta),
    .arr_v(arr_v), .arr_v_a(arr_v_a), .arr_f_b(arr_f_b), .arr_max(arr_max),
    .arr_v_tail(arr_v_tail), .arr_max_tail(arr_max_tail),
    .res_valid(res_valid), .res_score(res_score), .res_err(res_err), .res_ready(res_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chks(input string tag, input logic signed [CB-1:0] obs, input logic signed [CB-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Affine-gap local alignment of tq[0:tn-1] against qq[0:qn-1].
  function automatic int sw_ref(input int qn, input int tn);
    int h[0:16][0:8];
    int e[0:16][0:8];
    int f[0:16][0:8];
    int best = 0;
    for (int i = 0; i <= tn; i++)
      for (int j = 0; j <= qn; j++) begin
        h[i][j] = 0; e[i][j] = -10000; f[i][j] = -10000;
      end
    for (int i = 1; i <= tn; i++)
      for (int j = 1; j <= qn; j++) begin
        e[i][j] = imax(h[i][j-1] + al, e[i][j-1] + be);
        f[i][j] = imax(h[i-1][j] + al, f[i-1][j] + be);
        h[i][j] = imax(0, imax(h[i-1][j-1] + ((tq[i-1] == qq[j-1]) ? ma : mm),
                               imax(e[i][j], f[i][j])));
        best = imax(best, h[i][j]);
      end
    return best;
  endfunction

  function automatic logic [3*PE-1:0] qexp(input int n);
    logic [3*PE-1:0] v = '0;
    for (int i = 0; i < n; i++) v[3*i +: 3] = {1'b1, qq[i]};
    return v;
  endfunction

  // Stub chain tail: noise below the expected best during the run window,
  // the best itself only in the final drain cycle, a large decoy otherwise.
  always @(negedge clk) begin
    if (busy === 1'b1 && res_valid === 1'b0) begin
      arr_v_tail = CB'(-int'($urandom_range(1, 3000)));
      if (win_pos == win_len - 1) arr_max_tail = CB'(peak_i);
      else if (peak_i > 0)        arr_max_tail = CB'(int'($urandom_range(0, peak_i - 1)));
      else                        arr_max_tail = '0;
      win_pos++;
    end else begin
      win_pos      = 0;
      arr_v_tail   = 16'sh7000;
      arr_max_tail = 16'sh7000;
    end
  end

  always @(negedge clk) begin
    if (busy === 1'b1 && res_valid === 1'b0) begin
      if (exp_tok.size() == 0) chk("tok_queue_empty", 64'(exp_tok.size()), 64'd1);
      else chk("arr_t_seq", 64'(arr_t), 64'(exp_tok.pop_front()));
    end
  end

  task automatic load(input int n, input bit use_last);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      q_valid = 1'b1; q_data = qq[i]; q_last = use_last && (i == n - 1);
      chk("q_ready_load", 64'(q_ready), 64'd1);
    end
    @(negedge clk);
    q_valid = 1'b0; q_last = 1'b0;
    qlen = n;
  endtask

  task automatic run(input int tn, input int drop_at, input bit hold, input bit abort);
    int i, k, acc_c, drops;
    bit dropped;
    logic signed [CB-1:0] s0;
    drops   = (drop_at > 0) ? 1 : 0;
    peak_i  = sw_ref(qlen, tn);
    win_len = 1 + tn + drops + PE + 3;
    sb_score.push_back(CB'(peak_i));
    sb_err.push_back(drop_at >= 0);
    exp_tok.push_back(TOK_BUBBLE);
    exp_tok.push_back(TOK_MARK);
    for (int j = 0; j < tn; j++) begin
      if (drop_at == j) exp_tok.push_back(TOK_BUBBLE);
      exp_tok.push_back({1'b1, tq[j]});
    end
    for (int j = 0; j < PE + 2; j++) exp_tok.push_back(TOK_BUBBLE);
    res_ready = !hold;

    @(negedge clk);
    cfg_match = CB'(ma); cfg_mismatch = CB'(mm); cfg_alpha = CB'(al); cfg_beta = CB'(be);
    start = 1'b1; q_valid = 1'b1; q_data = 2'd3;
    #1 chk("q_ready_vs_start", 64'(q_ready), 64'd0);
    @(negedge clk);
    start = 1'b0; q_valid = 1'b0;
    cfg_match = 16'sd99; cfg_alpha = 16'sd77;
    chk("busy_mark", 64'(busy), 64'd1);
    chk("arr_q_kept", 64'(arr_q), 64'(qexp(qlen)));
    chks("arr_match", arr_match, CB'(ma));
    chks("arr_mismatch", arr_mismatch, CB'(mm));
    chks("arr_beta", arr_beta, CB'(be));

    i = 0; k = 0; dropped = 0; acc_c = 0;
    while (i < tn && k < 100) begin
      @(negedge clk); k++;
      if (t_ready && drop_at == i && !dropped) begin
        t_valid = 1'b0; dropped = 1;
      end else begin
        t_valid = 1'b1; t_data = tq[i]; t_last = (i == tn - 1);
        if (t_ready) begin
          if (i == 0) acc_c = cyc;
          i++;
        end
      end
    end
    chk("stream_done", 64'(i), 64'(tn));
    @(negedge clk);
    t_valid = 1'b0; t_last = 1'b0;
    chks("arr_v_a_latched", arr_v_a, CB'(al));
    chks("arr_f_b_latched", arr_f_b, CB'(al));
    chks("arr_v_zero", arr_v, 16'sd0);
    chks("arr_max_zero", arr_max, 16'sd0);

    if (abort) begin
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_arr_q", 64'(arr_q), 64'd0);
      chk("rst_arr_t", 64'(arr_t), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_res_valid", 64'(res_valid), 64'd0);
      chks("rst_arr_alpha", arr_alpha, 16'sd0);
      chks("rst_res_score", res_score, 16'sd0);
      chk("rst_q_ready", 64'(q_ready), 64'd1);
      sb_score.delete(); sb_err.delete(); exp_tok.delete();
      qlen = 0;
      @(negedge clk);
      rst_n = 1'b1;
      return;
    end

    k = 0;
    while (res_valid !== 1'b1 && k < 300) begin
      @(negedge clk); k++;
    end
    chk("res_valid_seen", 64'(res_valid), 64'd1);
    chk("latency", 64'(cyc - acc_c), 64'(tn + drops + PE + 3));
    chk("tok_all_seen", 64'(exp_tok.size()), 64'd0);
    if (hold) begin
      s0 = res_score;
      for (int j = 0; j < 10; j++) begin
        @(negedge clk);
        start = (j % 2 == 0);
        chk("hold_res_valid", 64'(res_valid), 64'd1);
        chks("hold_res_score", res_score, s0);
      end
      start = 1'b0; res_ready = 1'b1;
    end
    chks("res_score", res_score, sb_score.pop_front());
    chk("res_err", 64'(res_err), 64'(sb_err.pop_front()));
    @(negedge clk);
    chk("idle_after_done", 64'(busy), 64'd0);
    chk("res_valid_drop", 64'(res_valid), 64'd0);
  endtask

  initial begin
    q_valid = 0; q_data = 0; q_last = 0; start = 0;
    t_valid = 0; t_data = 0; t_last = 0; res_ready = 1;
    cfg_match = 0; cfg_mismatch = 0; cfg_alpha = 0; cfg_beta = 0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_arr_q", 64'(arr_q), 64'd0);
    chk("reset_arr_t", 64'(arr_t), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_res_valid", 64'(res_valid), 64'd0);
    chk("reset_q_ready", 64'(q_ready), 64'd1);
    chk("reset_t_ready", 64'(t_ready), 64'd0);
    chks("reset_res_score", res_score, 16'sd0);
    chks("reset_arr_alpha", arr_alpha, 16'sd0);

    // full bank without q_last: completes on the last position
    for (int i = 0; i < PE; i++) qq[i] = 2'(i % 4);
    load(PE, 1'b0);
    chk("arr_q_full", 64'(arr_q), 64'(qexp(PE)));
    chk("busy_after_full", 64'(busy), 64'd0);

    qq[0] = 2'd0; qq[1] = 2'd1; qq[2] = 2'd2; qq[3] = 2'd3;
    load(4, 1'b1);
    chk("arr_q_acgt", 64'(arr_q), 64'h000FAC);

    for (int i = 0; i < 4; i++) tq[i] = 2'(i);
    run(4, -1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tq[i] = 2'd3;
    run(4, -1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tq[i] = 2'(i);
    run(4, 2, 1'b0, 1'b0);
    run(4, -1, 1'b1, 1'b0);
    run(4, -1, 1'b0, 1'b1);

    // query lost by reset: start must be ignored
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    chk("start_no_query_busy", 64'(busy), 64'd0);
    chk("start_no_query_res", 64'(res_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sw_array_ctrl.md
Name: sw_array_ctrl

Overview:
- Sequencer for the linear systolic chain of Smith-Waterman PEs.
- Loads and holds the query bank (one 3-bit q per PE), latches scoring configuration, and injects the target stream plus a query-epoch marker at the chain head.
- Drains the pipeline and reduces the tail outputs to one best local-alignment score per run, returned on a valid/ready result port.

Parameters:
- PE_NUM, 64, number of PEs in the chain (max query length).
- CALC_BIT, 16, score width; from shared package, must match PE.
- CNT_BIT, 8, width of drain/query counters; must satisfy 2^CNT_BIT > PE_NUM+2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_match, cfg_mismatch, cfg_alpha, cfg_beta  in  CALC_BIT each  scoring config; signed; sampled on accepted start
- q_valid  in  1  query beat valid
- q_data  in  2  query nucleotide
- q_last  in  1  last query beat
- q_ready  out  1  query beat accepted when q_valid&q_ready
- start  in  1  run request pulse
- t_valid  in  1  target beat valid
- t_data  in  2  target nucleotide
- t_last  in  1  last target beat
- t_ready  out  1  target beat accepted when t_valid&t_ready
- arr_t  out  3  head t_in: {valid, nt}, 3'b001 = epoch marker, 3'b000 = bubble
- arr_q  out  3*PE_NUM  q bank; PE i uses bits [3i+2:3i]; bit2 = active
- arr_match, arr_mismatch, arr_alpha, arr_beta  out  CALC_BIT each  latched config to all PEs
- arr_v, arr_v_a, arr_f_b, arr_max  out  CALC_BIT each  head boundary values
- arr_v_tail, arr_max_tail  in  CALC_BIT each  v_out / max_out of PE PE_NUM-1
- res_valid  out  1  result valid
- res_score  out  CALC_BIT  best score
- res_err  out  1  target underrun occurred during the run
- res_ready  in  1  result accepted
- busy  out  1  state not IDLE/LOADQ

Behaviour:
- Reset values: all outputs 0; arr_q all 0 (no active PE); state IDLE; q_len 0; accumulator 0.
- States: IDLE, LOADQ, MARK, STREAM, DRAIN, DONE.
- q_ready is high only in IDLE and LOADQ.
- Query load:
  - First accepted q beat in IDLE clears the whole bank, writes position 0 as {1,q_data} and enters LOADQ.
  - Each later beat writes position q_cnt and increments q_cnt.
  - The load completes on q_last, or on the beat written to position PE_NUM-1; that beat sets q_len and returns to IDLE.
  - A query beat that would exceed PE_NUM positions is not accepted: q_ready is 0 in that case.
  - The query persists across runs until the next load.
- start:
  - Acted on only in IDLE with q_len>0; otherwise ignored, no response.
  - start and q_valid in the same IDLE cycle: start wins, q_ready is 0 that cycle.
  - On accept: cfg latched to arr_* outputs, accumulator cleared, res_err cleared, state goes to MARK.
- MARK: one cycle, arr_t=3'b001; then STREAM.
- STREAM:
  - t_ready=1.
  - Accepted beat: arr_t={1,t_data} registered, so it appears at the head the cycle after acceptance.
  - t_valid=0: arr_t=3'b000, res_err set sticky. The PE has no enable, so the bubble corrupts the run; the run still completes.
  - Accepted beat with t_last: go to DRAIN, drain counter = PE_NUM+2.
- DRAIN:
  - t_ready=0, arr_t=3'b000.
  - Counter decrements each cycle; at 0 go to DONE.
- Head boundary, constant throughout: arr_v=0, arr_max=0, arr_v_a=cfg_alpha, arr_f_b=cfg_alpha.
- Accumulator:
  - Update each cycle in MARK, STREAM and DRAIN: acc = signed max(acc, arr_max_tail, arr_v_tail).
  - acc is never below 0.
- DONE:
  - res_valid=1; res_score=acc and res_err held stable until res_ready.
  - On res_valid&res_ready, go to IDLE the next cycle.
  - Same-cycle start is ignored.
- Latency: first symbol acceptance to res_valid = L+PE_NUM+3 cycles for target length L, with res_ready held high.
- Asynchronous reset mid-run: returns to reset state immediately, query lost; no partial result is emitted.

Decomposition:
- Shared package (parameter include):
  - CALC_BIT.
  - Token encodings: TOK_BUBBLE=3'b000, TOK_MARK=3'b001, TOK_VALID bit 2.
  - State encodings.
- Sub-module sw_q_bank holds the PE_NUM×3 register file: clear, indexed write, flat output. The FSM, counters and accumulator stay in the top.

Test Plan:
- Reset, then idle: all outputs 0, q_ready=1, busy=0.
- Load query ACGT (4 beats, q_last on 4th): arr_q[11:0]={1,T,1,G,1,C,1,A} in bit order; all other positions 0; q_len=4.
- Start with cfg match=2, mismatch=-1, alpha=-2, beta=-1, target ACGT: exactly one arr_t=001 cycle, then 4 valid tokens, then PE_NUM+2 bubbles; res_score=8, res_err=0.
- Same query, target TTTT: res_score=2; back-to-back second run without reload accepted.
- t_valid dropped one cycle mid-STREAM: arr_t=000 that cycle; res_err=1 at DONE.
- res_ready held low 10 cycles: res_valid and res_score stable; start pulses ignored. Also assert rst_n mid-DRAIN: all outputs 0 next edge and arr_q cleared.
